// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the 640x480@60 Hz raster generator.
package vga_pkg;
    localparam int COORD_W = 11;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_mod_counter.sv
// Modulo counter 0..MAX advancing on en; carry marks the wrapping step.
module vga_mod_counter
    import vga_pkg::*;
#(
    parameter int MAX = DEF_H_TOTAL - 1
) (
    input  logic               CLK50MHZ,
    input  logic               RST,
    input  logic               en,
    output logic [COORD_W-1:0] cnt,
    output logic               carry
);
    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == MAX_C) ? '0 : cnt + COORD_W'(1);
        end
    end

    assign carry = en && (cnt == MAX_C);
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: divide-by-two pixel enable, h/v counters and a registered
// output stage carrying sync, coordinates, displaying and frame_start.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               CLK50MHZ,
    input  logic               RST,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               displaying,
    output logic               frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_VIS_C     = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_C     = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_LO_C = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_HI_C = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_LO_C = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_HI_C = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               ce;
    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               h_carry;
    logic               v_carry;
    logic               frame_wrapped;

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            ce <= 1'b0;
        end else begin
            ce <= ~ce;
        end
    end

    vga_mod_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .en       (ce),
        .cnt      (hcnt),
        .carry    (h_carry)
    );

    vga_mod_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .en       (h_carry),
        .cnt      (vcnt),
        .carry    (v_carry)
    );

    // frame_wrapped marks that the counters have just entered (0,0) afresh,
    // either out of reset or via the frame wrap, so only the first output
    // cycle of that pixel raises frame_start.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            x             <= '0;
            y             <= '0;
            displaying    <= 1'b0;
            VGA_HSYNC     <= 1'b1;
            VGA_VSYNC     <= 1'b1;
            frame_start   <= 1'b0;
            frame_wrapped <= 1'b1;
        end else begin
            x             <= hcnt;
            y             <= vcnt;
            displaying    <= (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
            VGA_HSYNC     <= ~in_window(hcnt, H_SYNC_LO_C, H_SYNC_HI_C);
            VGA_VSYNC     <= ~in_window(vcnt, V_SYNC_LO_C, V_SYNC_HI_C);
            frame_start   <= frame_wrapped && (hcnt == '0) && (vcnt == '0);
            frame_wrapped <= v_carry;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default-geometry and a tiny-geometry instance
// share RST and are checked every clock against a raster model derived from edge count.
module tb_vga_timing;
    logic        CLK50MHZ = 1'b0;
    logic        RST;

    logic        d_hs, d_vs, d_disp, d_fs;
    logic [10:0] d_x, d_y;
    logic        s_hs, s_vs, s_disp, s_fs;
    logic [10:0] s_x, s_y;

    always #10 CLK50MHZ = ~CLK50MHZ;

    vga_timing u_dflt (
        .CLK50MHZ    (CLK50MHZ),
        .RST         (RST),
        .VGA_HSYNC   (d_hs),
        .VGA_VSYNC   (d_vs),
        .x           (d_x),
        .y           (d_y),
        .displaying  (d_disp),
        .frame_start (d_fs)
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .CLK50MHZ    (CLK50MHZ),
        .RST         (RST),
        .VGA_HSYNC   (s_hs),
        .VGA_VSYNC   (s_vs),
        .x           (s_x),
        .y           (s_y),
        .displaying  (s_disp),
        .frame_start (s_fs)
    );

    typedef struct {
        int x;
        int y;
        bit disp;
        bit hs;
        bit vs;
        bit fs;
    } exp_t;

    typedef struct {
        exp_t d;
        exp_t s;
    } pair_t;

    pair_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 0;

    // k = edges since the last reset edge (k = 0: that reset edge itself).
    // Output at edge k shows pixel (k-1)/2 of a raster scanned row-major.
    function automatic exp_t model(input int k, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb);
        exp_t e;
        int   ht, vt, p;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (k == 0) begin
            e = '{x: 0, y: 0, disp: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        end else begin
            p      = ((k - 1) / 2) % (ht * vt);
            e.x    = p % ht;
            e.y    = p / ht;
            e.disp = (e.x < hv) && (e.y < vv);
            e.hs   = !((e.x >= hv + hf) && (e.x < hv + hf + hsw));
            e.vs   = !((e.y >= vv + vf) && (e.y < vv + vf + vsw));
            e.fs   = ((k - 1) % (2 * ht * vt)) == 0;
        end
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e, input logic [10:0] ax,
                             input logic [10:0] ay, input logic ad, input logic ah,
                             input logic av, input logic af);
        n_cmp++;
        if ({ax, ay, ad, ah, av, af} !== {11'(e.x), 11'(e.y), e.disp, e.hs, e.vs, e.fs}) begin
            n_bad++;
            $display("FAIL %s @%0t: got x=%0d y=%0d disp=%b hs=%b vs=%b fs=%b, expected x=%0d y=%0d disp=%b hs=%b vs=%b fs=%b",
                     name, $time, ax, ay, ad, ah, av, af,
                     e.x, e.y, e.disp, e.hs, e.vs, e.fs);
        end
    endtask

    // Monitor: each falling edge pops the expectation for the preceding rising edge.
    initial begin
        pair_t p;
        forever begin
            @(negedge CLK50MHZ);
            if (!done && sb.size() > 0) begin
                p = sb.pop_front();
                check_out("dflt", p.d, d_x, d_y, d_disp, d_hs, d_vs, d_fs);
                check_out("small", p.s, s_x, s_y, s_disp, s_hs, s_vs, s_fs);
            end
        end
    end

    // Driver: picks RST for the next rising edge and queues what that edge must show.
    initial begin
        int    k;
        int    rst_left;
        bit    mid_done;
        bit    r;
        exp_t  last_d;
        pair_t p;
        k        = 0;
        rst_left = 0;
        mid_done = 0;
        last_d   = model(0, 640, 16, 96, 48, 480, 10, 2, 33);
        RST      = 1'b1;
        for (int c = 0; c < 11000; c++) begin
            if (c < 5) begin
                r = 1'b1;
            end else if (c < 3600) begin
                // one-clock reset mid-line while hsync is low
                r = !mid_done && last_d.x == 700 && last_d.y == 1 && !last_d.hs;
                if (r) mid_done = 1;
            end else if (c < 5600) begin
                r = 1'b0;
            end else if (rst_left > 0) begin
                r = 1'b1;
                rst_left--;
            end else if ($urandom_range(999) == 0) begin
                r = 1'b1;
                rst_left = $urandom_range(2);
            end else begin
                r = 1'b0;
            end
            RST = r;
            k   = r ? 0 : k + 1;
            p.d = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
            p.s = model(k, 8, 2, 3, 3, 4, 1, 1, 1);
            sb.push_back(p);
            last_d = p.d;
            @(posedge CLK50MHZ);
            #1;
        end
        @(negedge CLK50MHZ);
        #1;
        done = 1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        n_cmp++;
        if (!mid_done) begin
            n_bad++;
            $display("FAIL mid_reset: trigger point x=700 y=1 never observed in model, expected 1 got 0");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
